dmem_access_unit: RTL and testbench

Load/store initiator that sits between the CPU datapath and the data port of the integrated instruction/data memory. It accepts one byte, halfword or word load/store request at a time and drives the memory's `data_addr`, `data_in`, `mem_read` and `mem_write`. Sub-word stores are performed as an aligned word read-modify-write. Accesses are range- and alignment-checked against the data region, and loads are returned extended to 32 bits.

---
 rtl/dmem_access_unit.sv | 278 +++++++++++++++++++++++++++
 tb/tb_dmem_access_unit.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_unit.sv
// -----------------------------------------------------------------------------
// dmem_access_unit
// Load/store initiator between the CPU datapath and the data port of the
// shared instruction/data memory. It accepts one byte/half/word request at a
// time, range- and alignment-checks it against the data region, performs
// sub-word stores as an aligned read-modify-write, and returns loads extended
// to 32 bits.
//
// Ports
//   clk, reset      : single clock, synchronous active-high reset
//   req_valid/ready : request handshake, accepted when both are high
//   req_write       : 1 = store, 0 = load
//   req_size        : 00 byte, 01 half, 10 word, 11 reserved (faults)
//   req_signed      : sign-extend sub-word loads
//   req_addr        : byte address
//   req_wdata       : right-justified store data
//   resp_valid      : one-cycle completion pulse
//   resp_rdata      : extended load data (0 for stores and faults)
//   resp_fault      : misaligned / out of range / reserved size
//   data_addr       : word-aligned memory address (registered)
//   data_in         : memory write data (registered)
//   mem_read        : memory read enable (registered)
//   mem_write       : memory write strobe (registered)
//   data_out        : combinational little-endian read data from memory
// -----------------------------------------------------------------------------
module dmem_access_unit #(
   parameter logic [31:0] DATA_LIMIT = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_fault,
   output logic [31:0] data_addr,
   output logic [31:0] data_in,
   output logic        mem_read,
   output logic        mem_write,
   input  logic [31:0] data_out
);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RD   = 2'b01,
      S_WR   = 2'b10,
      S_RESP = 2'b11
   } state_t;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   // Extract the addressed lane of a memory word and extend it to 32 bits.
   function automatic logic [31:0] load_extend(
      input logic [31:0] word,
      input logic [1:0]  lane,
      input logic [1:0]  size,
      input logic        sext
   );
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] result;
      case (lane)
         2'b00:   b = word[7:0];
         2'b01:   b = word[15:8];
         2'b10:   b = word[23:16];
         2'b11:   b = word[31:24];
         default: b = 8'h00;
      endcase
      if (lane[1]) begin
         h = word[31:16];
      end else begin
         h = word[15:0];
      end
      case (size)
         SZ_BYTE: result = sext ? {{24{b[7]}}, b} : {24'h00_0000, b};
         SZ_HALF: result = sext ? {{16{h[15]}}, h} : {16'h0000, h};
         default: result = word;
      endcase
      return result;
   endfunction

   // Replace the addressed lane of a memory word with the store data.
   function automatic logic [31:0] lane_merge(
      input logic [31:0] word,
      input logic [31:0] wdata,
      input logic [1:0]  lane,
      input logic [1:0]  size
   );
      logic [31:0] result;
      result = word;
      case (size)
         SZ_BYTE: begin
            case (lane)
               2'b00:   result[7:0]   = wdata[7:0];
               2'b01:   result[15:8]  = wdata[7:0];
               2'b10:   result[23:16] = wdata[7:0];
               2'b11:   result[31:24] = wdata[7:0];
               default: result        = word;
            endcase
         end
         SZ_HALF: begin
            if (lane[1]) begin
               result[31:16] = wdata[15:0];
            end else begin
               result[15:0]  = wdata[15:0];
            end
         end
         default: result = wdata;
      endcase
      return result;
   endfunction

   state_t      state_q, state_d;
   logic [1:0]  lane_q, lane_d;
   logic [1:0]  size_q, size_d;
   logic        signed_q, signed_d;
   logic        write_q, write_d;
   logic [31:0] wdata_q, wdata_d;
   logic        req_ready_q, req_ready_d;
   logic        resp_valid_q, resp_valid_d;
   logic        resp_fault_q, resp_fault_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic [31:0] data_addr_q, data_addr_d;
   logic [31:0] data_in_q, data_in_d;
   logic        mem_read_q, mem_read_d;
   logic        mem_write_q, mem_write_d;

   logic [32:0] access_end_s;
   logic        shape_fault_s;
   logic        range_fault_s;
   logic        fault_s;

   // Request legality: shape (size/alignment) and range against the data region.
   always_comb begin
      access_end_s  = {1'b0, req_addr} + 33'd1;
      shape_fault_s = 1'b0;
      case (req_size)
         SZ_BYTE: begin
            access_end_s  = {1'b0, req_addr} + 33'd1;
            shape_fault_s = 1'b0;
         end
         SZ_HALF: begin
            access_end_s  = {1'b0, req_addr} + 33'd2;
            shape_fault_s = req_addr[0];
         end
         SZ_WORD: begin
            access_end_s  = {1'b0, req_addr} + 33'd4;
            shape_fault_s = (req_addr[1:0] != 2'b00);
         end
         default: begin
            access_end_s  = {1'b0, req_addr} + 33'd1;
            shape_fault_s = 1'b1;
         end
      endcase
      // 33-bit sum so addresses near 2^32 cannot wrap back into range.
      range_fault_s = (access_end_s > {1'b0, DATA_LIMIT});
      fault_s       = shape_fault_s | range_fault_s;
   end

   // Next-state and next-output computation for the access sequencer.
   always_comb begin
      state_d      = state_q;
      lane_d       = lane_q;
      size_d       = size_q;
      signed_d     = signed_q;
      write_d      = write_q;
      wdata_d      = wdata_q;
      data_addr_d  = data_addr_q;
      data_in_d    = data_in_q;
      resp_valid_d = 1'b0;
      resp_fault_d = 1'b0;
      resp_rdata_d = 32'h0000_0000;

      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               lane_d   = req_addr[1:0];
               size_d   = req_size;
               signed_d = req_signed;
               write_d  = req_write;
               wdata_d  = req_wdata;
               if (fault_s) begin
                  // No memory cycle; memory-side registers keep their values.
                  state_d      = S_RESP;
                  resp_valid_d = 1'b1;
                  resp_fault_d = 1'b1;
               end else if (!req_write || (req_size != SZ_WORD)) begin
                  state_d     = S_RD;
                  data_addr_d = {req_addr[31:2], 2'b00};
               end else begin
                  state_d     = S_WR;
                  data_addr_d = {req_addr[31:2], 2'b00};
                  data_in_d   = req_wdata;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RD: begin
            if (write_q) begin
               state_d   = S_WR;
               data_in_d = lane_merge(data_out, wdata_q, lane_q, size_q);
            end else begin
               state_d      = S_RESP;
               resp_valid_d = 1'b1;
               resp_rdata_d = load_extend(data_out, lane_q, size_q, signed_q);
            end
         end
         S_WR: begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Strobes are decoded from the next state so they come straight off flops.
      req_ready_d = (state_d == S_IDLE);
      mem_read_d  = (state_d == S_RD);
      mem_write_d = (state_d == S_WR);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         lane_q       <= 2'b00;
         size_q       <= 2'b00;
         signed_q     <= 1'b0;
         write_q      <= 1'b0;
         wdata_q      <= 32'h0000_0000;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_fault_q <= 1'b0;
         resp_rdata_q <= 32'h0000_0000;
         data_addr_q  <= 32'h0000_0000;
         data_in_q    <= 32'h0000_0000;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         lane_q       <= lane_d;
         size_q       <= size_d;
         signed_q     <= signed_d;
         write_q      <= write_d;
         wdata_q      <= wdata_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_fault_q <= resp_fault_d;
         resp_rdata_q <= resp_rdata_d;
         data_addr_q  <= data_addr_d;
         data_in_q    <= data_in_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_fault = resp_fault_q;
   assign resp_rdata = resp_rdata_q;
   assign data_addr  = data_addr_q;
   assign data_in    = data_in_q;
   assign mem_read   = mem_read_q;
   assign mem_write  = mem_write_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_dmem_access_unit
// Directed bench for dmem_access_unit with a behavioural word memory on the
// data port. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_dmem_access_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_fault;
   logic [31:0] data_addr;
   logic [31:0] data_in;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] data_out;

   logic [31:0] mem [0:4095];

   int vectors     = 0;
   int miscompares = 0;

   dmem_access_unit dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_fault (resp_fault),
      .data_addr  (data_addr),
      .data_in    (data_in),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .data_out   (data_out)
   );

   always #5 clk = ~clk;

   // Behavioural memory: combinational read, write on the rising edge.
   assign data_out = (data_addr < 32'h0000_4000) ? mem[data_addr[13:2]] : 32'h0000_0000;

   always @(posedge clk) begin
      if (mem_write && (data_addr < 32'h0000_4000)) begin
         mem[data_addr[13:2]] <= data_in;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chkb(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // One request, then observe four cycles and check latency, memory cycles and response.
   task automatic access(
      input string       tag,
      input logic        wr,
      input logic [1:0]  sz,
      input logic        sg,
      input logic [31:0] addr,
      input logic [31:0] wdata,
      input int          exp_lat,
      input int          exp_rd,
      input int          exp_wr,
      input logic [31:0] exp_rdata,
      input logic        exp_fault,
      input logic [31:0] exp_daddr,
      input logic [31:0] exp_din
   );
      int          lat;
      int          pulses;
      int          rdc;
      int          wrc;
      int          both;
      logic [31:0] rdata_seen;
      logic [31:0] daddr_seen;
      logic [31:0] din_seen;
      logic        fault_seen;
      lat = 0; pulses = 0; rdc = 0; wrc = 0; both = 0;
      rdata_seen = 32'h0; daddr_seen = 32'h0; din_seen = 32'h0; fault_seen = 1'b0;
      @(negedge clk);
      chkb({tag, " ready_before"}, req_ready, 1'b1);
      req_valid  = 1'b1;
      req_write  = wr;
      req_size   = sz;
      req_signed = sg;
      req_addr   = addr;
      req_wdata  = wdata;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         req_valid = 1'b0;
         if (resp_valid) begin
            pulses++;
            lat        = c;
            rdata_seen = resp_rdata;
            fault_seen = resp_fault;
         end
         if (mem_read) begin
            rdc++;
            daddr_seen = data_addr;
         end
         if (mem_read && mem_write) begin
            both++;
         end
         if (mem_write) begin
            wrc++;
            daddr_seen = data_addr;
            din_seen   = data_in;
            #4;
            chk({tag, " addr_stable"}, data_addr, daddr_seen);
            chk({tag, " din_stable"}, data_in, din_seen);
         end
      end
      chk({tag, " pulses"}, pulses, 32'd1);
      chk({tag, " latency"}, lat, exp_lat);
      chk({tag, " reads"}, rdc, exp_rd);
      chk({tag, " writes"}, wrc, exp_wr);
      chk({tag, " rd_wr_overlap"}, both, 32'd0);
      chk({tag, " rdata"}, rdata_seen, exp_rdata);
      chkb({tag, " fault"}, fault_seen, exp_fault);
      chkb({tag, " ready_after"}, req_ready, 1'b1);
      if ((exp_rd + exp_wr) > 0) begin
         chk({tag, " data_addr"}, daddr_seen, exp_daddr);
      end
      if (exp_wr > 0) begin
         chk({tag, " data_in"}, din_seen, exp_din);
         chk({tag, " data_in_hold"}, data_in, exp_din);
         chk({tag, " data_addr_hold"}, data_addr, exp_daddr);
      end
   endtask

   initial begin
      int wr_count;
      reset      = 1'b1;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_size   = 2'b00;
      req_signed = 1'b0;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      repeat (2) @(negedge clk);

      // Reset state
      chkb("rst ready", req_ready, 1'b1);
      chkb("rst resp_valid", resp_valid, 1'b0);
      chkb("rst resp_fault", resp_fault, 1'b0);
      chk("rst resp_rdata", resp_rdata, 32'h0);
      chk("rst data_addr", data_addr, 32'h0);
      chk("rst data_in", data_in, 32'h0);
      chkb("rst mem_read", mem_read, 1'b0);
      chkb("rst mem_write", mem_write, 1'b0);
      reset = 1'b0;

      // Preload through the unit with word stores
      access("sw_10", 1'b1, 2'b10, 1'b0, 32'h10, 32'h8899_AABB, 2, 0, 1, 32'h0, 1'b0, 32'h10, 32'h8899_AABB);
      access("sw_20", 1'b1, 2'b10, 1'b0, 32'h20, 32'h1122_3344, 2, 0, 1, 32'h0, 1'b0, 32'h20, 32'h1122_3344);

      // Loads with extension
      access("lb_11",  1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 2, 1, 0, 32'hFFFF_FFAA, 1'b0, 32'h10, 32'h0);
      access("lbu_11", 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 2, 1, 0, 32'h0000_00AA, 1'b0, 32'h10, 32'h0);
      access("lhu_12", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 2, 1, 0, 32'h0000_8899, 1'b0, 32'h10, 32'h0);
      access("lh_12",  1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 2, 1, 0, 32'hFFFF_8899, 1'b0, 32'h10, 32'h0);
      access("lw_10",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, 1, 0, 32'h8899_AABB, 1'b0, 32'h10, 32'h0);

      // Sub-word store read-modify-write
      access("sb_13",  1'b1, 2'b00, 1'b0, 32'h13, 32'h1234_565C, 3, 1, 1, 32'h0, 1'b0, 32'h10, 32'h5C99_AABB);
      access("lw_10b", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, 1, 0, 32'h5C99_AABB, 1'b0, 32'h10, 32'h0);
      access("lbu_13", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 2, 1, 0, 32'h0000_005C, 1'b0, 32'h10, 32'h0);
      access("lh_10",  1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 2, 1, 0, 32'hFFFF_AABB, 1'b0, 32'h10, 32'h0);

      // Range boundary
      access("sw_2ffc", 1'b1, 2'b10, 1'b0, 32'h2FFC, 32'h1234_5678, 2, 0, 1, 32'h0, 1'b0, 32'h2FFC, 32'h1234_5678);
      access("lb_2fff", 1'b0, 2'b00, 1'b1, 32'h2FFF, 32'h0, 2, 1, 0, 32'h0000_0012, 1'b0, 32'h2FFC, 32'h0);
      access("lh_2ffe", 1'b0, 2'b01, 1'b1, 32'h2FFE, 32'h0, 2, 1, 0, 32'h0000_1234, 1'b0, 32'h2FFC, 32'h0);

      // Faults: response next cycle, no memory cycle
      access("sw_3000", 1'b1, 2'b10, 1'b0, 32'h3000, 32'hDEAD_BEEF, 1, 0, 0, 32'h0, 1'b1, 32'h0, 32'h0);
      access("lh_11",   1'b0, 2'b01, 1'b1, 32'h11, 32'h0, 1, 0, 0, 32'h0, 1'b1, 32'h0, 32'h0);
      access("lw_12",   1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 1, 0, 0, 32'h0, 1'b1, 32'h0, 32'h0);
      access("size_11", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1, 0, 0, 32'h0, 1'b1, 32'h0, 32'h0);
      access("lb_3000", 1'b0, 2'b00, 1'b0, 32'h3000, 32'h0, 1, 0, 0, 32'h0, 1'b1, 32'h0, 32'h0);
      access("lw_wrap", 1'b0, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'h0, 1, 0, 0, 32'h0, 1'b1, 32'h0, 32'h0);
      access("sb_2fff", 1'b1, 2'b00, 1'b0, 32'h2FFF, 32'h0000_00A5, 3, 1, 1, 32'h0, 1'b0, 32'h2FFC, 32'hA534_5678);

      // Reset during RD of a sub-word store
      @(negedge clk);
      req_valid  = 1'b1;
      req_write  = 1'b1;
      req_size   = 2'b01;
      req_signed = 1'b0;
      req_addr   = 32'h20;
      req_wdata  = 32'h0000_BEEF;
      @(negedge clk);
      req_valid = 1'b0;
      chkb("rstmid in_rd", mem_read, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      chkb("rstmid ready", req_ready, 1'b1);
      chkb("rstmid resp_valid", resp_valid, 1'b0);
      chkb("rstmid resp_fault", resp_fault, 1'b0);
      chk("rstmid resp_rdata", resp_rdata, 32'h0);
      chk("rstmid data_addr", data_addr, 32'h0);
      chk("rstmid data_in", data_in, 32'h0);
      chkb("rstmid mem_read", mem_read, 1'b0);
      chkb("rstmid mem_write", mem_write, 1'b0);
      reset    = 1'b0;
      wr_count = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (mem_write || resp_valid) begin
            wr_count++;
         end
      end
      chk("rstmid no_activity", wr_count, 32'd0);
      access("lw_20", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 2, 1, 0, 32'h1122_3344, 1'b0, 32'h20, 32'h0);

      // Sub-word half store in upper lane
      access("sh_22", 1'b1, 2'b01, 1'b0, 32'h22, 32'hFFFF_BEEF, 3, 1, 1, 32'h0, 1'b0, 32'h20, 32'hBEEF_3344);
      access("lw_20b", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 2, 1, 0, 32'hBEEF_3344, 1'b0, 32'h20, 32'h0);

      // Back-to-back with req_valid held high
      @(negedge clk);
      req_valid  = 1'b1;
      req_write  = 1'b0;
      req_size   = 2'b10;
      req_signed = 1'b0;
      req_addr   = 32'h10;
      req_wdata  = 32'h0;
      chkb("b2b ready0", req_ready, 1'b1);
      @(negedge clk);
      chkb("b2b c1 ready", req_ready, 1'b0);
      chkb("b2b c1 mem_read", mem_read, 1'b1);
      chkb("b2b c1 resp_valid", resp_valid, 1'b0);
      req_write = 1'b1;
      req_addr  = 32'h14;
      req_wdata = 32'hCAFE_F00D;
      @(negedge clk);
      chkb("b2b c2 ready", req_ready, 1'b0);
      chkb("b2b c2 resp_valid", resp_valid, 1'b1);
      chk("b2b c2 rdata", resp_rdata, 32'h5C99_AABB);
      @(negedge clk);
      chkb("b2b c3 ready", req_ready, 1'b1);
      chkb("b2b c3 resp_valid", resp_valid, 1'b0);
      chkb("b2b c3 mem_write", mem_write, 1'b0);
      @(negedge clk);
      req_valid = 1'b0;
      chkb("b2b c4 ready", req_ready, 1'b0);
      chkb("b2b c4 mem_write", mem_write, 1'b1);
      chk("b2b c4 data_addr", data_addr, 32'h14);
      chk("b2b c4 data_in", data_in, 32'hCAFE_F00D);
      chkb("b2b c4 resp_valid", resp_valid, 1'b0);
      @(negedge clk);
      chkb("b2b c5 ready", req_ready, 1'b0);
      chkb("b2b c5 resp_valid", resp_valid, 1'b1);
      chkb("b2b c5 fault", resp_fault, 1'b0);
      chkb("b2b c5 mem_write", mem_write, 1'b0);
      @(negedge clk);
      chkb("b2b c6 ready", req_ready, 1'b1);
      chkb("b2b c6 resp_valid", resp_valid, 1'b0);
      access("lw_14", 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 2, 1, 0, 32'hCAFE_F00D, 1'b0, 32'h14, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
